// File: rtl/step_pair_streamer_if.sv
// Word-stream input and step-pair output bundle for step_pair_streamer.
// The streamer holds the master view; the witness source and the checker hold the slave view.
interface step_pair_streamer_if #(
    parameter int WORD_W = 32,
    parameter int STEP_W = 656
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [STEP_W-1:0] pair_step0;
    logic [STEP_W-1:0] pair_step1;
    logic              pair_valid;
    logic              pair_ready;
    logic              pair_ok;

    modport master (
        input  in_data, in_valid, in_last, pair_ready, pair_ok,
        output in_ready, pair_step0, pair_step1, pair_valid
    );

    modport slave (
        output in_data, in_valid, in_last, pair_ready, pair_ok,
        input  in_ready, pair_step0, pair_step1, pair_valid
    );
endinterface

// File: rtl/step_pair_streamer.sv
// Deserializes step records from a word stream, presents consecutive (step0, step1) pairs
// to a consistency checker and folds its ok results into a sticky trace verdict.
module step_pair_streamer #(
    parameter int WORD_W = 32,
    parameter int STEP_W = 656
) (
    input  logic                 clk,
    input  logic                 rst,
    step_pair_streamer_if.master bus,
    output logic                 done,
    output logic                 pass,
    output logic                 frame_err,
    output logic [31:0]          step_count,
    output logic [31:0]          fail_index
);
    localparam int NW     = (STEP_W + WORD_W - 1) / WORD_W;
    localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;
    localparam int LAST_W = STEP_W - (NW - 1) * WORD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_EMIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [STEP_W-1:0] cur_q, cur_d;
    logic [STEP_W-1:0] step0_q, step0_d;
    logic [STEP_W-1:0] step1_q, step1_d;
    logic              have_prev_q, have_prev_d;
    logic              last_seen_q, last_seen_d;
    logic              frame_err_q, frame_err_d;
    logic [31:0]       step_count_q, step_count_d;
    logic [31:0]       fail_index_q, fail_index_d;
    logic              started_q;
    logic [STEP_W-1:0] cur_next;
    logic              word_xfer;

    // in_ready stays low through reset and rises one cycle after release.
    assign bus.in_ready   = (state_q == S_FILL) && started_q;
    assign bus.pair_valid = (state_q == S_EMIT);
    assign bus.pair_step0 = step0_q;
    assign bus.pair_step1 = step1_q;
    assign word_xfer      = bus.in_valid && bus.in_ready;

    assign done       = (state_q == S_DONE);
    assign pass       = done && (fail_index_q == '1) && !frame_err_q;
    assign frame_err  = frame_err_q;
    assign step_count = step_count_q;
    assign fail_index = fail_index_q;

    // Merge the incoming word into its slot; the final word is truncated at STEP_W.
    always_comb begin
        cur_next = cur_q;
        for (int w = 0; w < NW - 1; w++) begin
            if (idx_q == IDX_W'(w)) cur_next[w*WORD_W +: WORD_W] = bus.in_data;
        end
        if (idx_q == LAST_IDX) cur_next[STEP_W-1 -: LAST_W] = bus.in_data[LAST_W-1:0];
    end

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cur_d        = cur_q;
        step0_d      = step0_q;
        step1_d      = step1_q;
        have_prev_d  = have_prev_q;
        last_seen_d  = last_seen_q;
        frame_err_d  = frame_err_q;
        step_count_d = step_count_q;
        fail_index_d = fail_index_q;

        unique case (state_q)
            S_FILL: begin
                if (word_xfer) begin
                    cur_d = cur_next;
                    if (idx_q != LAST_IDX) begin
                        if (bus.in_last) begin
                            frame_err_d = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        idx_d       = '0;
                        last_seen_d = bus.in_last;
                        if (!have_prev_q) begin
                            if (bus.in_last) begin
                                state_d = S_DONE;
                            end else begin
                                step0_d     = cur_next;
                                have_prev_d = 1'b1;
                            end
                        end else begin
                            step1_d = cur_next;
                            state_d = S_EMIT;
                        end
                    end
                end
            end
            S_EMIT: begin
                if (bus.pair_ready) begin
                    if (step_count_q != '1) step_count_d = step_count_q + 32'd1;
                    if (!bus.pair_ok && (fail_index_q == '1)) fail_index_d = step_count_q;
                    step0_d = step1_q;
                    state_d = last_seen_q ? S_DONE : S_FILL;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only; the wide step buffers are
    // reset too because a reset must discard any partial step or pending pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FILL;
            idx_q        <= '0;
            cur_q        <= '0;
            step0_q      <= '0;
            step1_q      <= '0;
            have_prev_q  <= 1'b0;
            last_seen_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            step_count_q <= '0;
            fail_index_q <= '1;
            started_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cur_q        <= cur_d;
            step0_q      <= step0_d;
            step1_q      <= step1_d;
            have_prev_q  <= have_prev_d;
            last_seen_q  <= last_seen_d;
            frame_err_q  <= frame_err_d;
            step_count_q <= step_count_d;
            fail_index_q <= fail_index_d;
            started_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_step_pair_streamer.sv
// Directed bench for step_pair_streamer: pair handshakes, stalls, framing errors,
// single-step traces and mid-trace reset, each step built from 21 known words.
module tb_step_pair_streamer;
    localparam int WORD_W = 32;
    localparam int STEP_W = 656;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done, pass, frame_err;
    logic [31:0] step_count, fail_index;
    int          n_assert = 0;
    int          n_fail   = 0;
    logic        saw_pv   = 1'b0;

    step_pair_streamer_if #(.WORD_W(WORD_W), .STEP_W(STEP_W)) bus ();

    step_pair_streamer #(.WORD_W(WORD_W), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.master),
        .done       (done),
        .pass       (pass),
        .frame_err  (frame_err),
        .step_count (step_count),
        .fail_index (fail_index)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.pair_valid) saw_pv = 1'b1;

    task automatic chk(input string tag, input logic [STEP_W-1:0] obs, input logic [STEP_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word w of step s; word 20 carries 16'hDEAD in the bits beyond the record.
    function automatic logic [31:0] word_of(input int s, input int w);
        logic [7:0] sb = 8'(s);
        logic [7:0] wb = 8'(w);
        if (w == 20) return {16'hDEAD, sb, wb};
        return {sb, 8'h5A, sb, wb};
    endfunction

    function automatic logic [STEP_W-1:0] exp_step(input int s);
        logic [671:0] p = '0;
        for (int w = 0; w < 21; w++) p[w*32 +: 32] = word_of(s, w);
        return p[STEP_W-1:0];
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_step(input int s, input logic last);
        for (int w = 0; w < 21; w++) send_word(word_of(s, w), last && (w == 20));
    endtask

    task automatic handshake(input logic ok);
        @(negedge clk);
        bus.pair_ok    = ok;
        bus.pair_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.pair_ready = 1'b0;
        bus.pair_ok    = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.pair_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pair_trace(input logic ok0, input logic ok1);
        send_step(0, 1'b0);
        send_step(1, 1'b0);
        handshake(ok0);
        send_step(2, 1'b1);
        handshake(ok1);
    endtask

    initial begin
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.in_last    = 1'b0;
        bus.pair_ready = 1'b0;
        bus.pair_ok    = 1'b1;

        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_pair_valid", bus.pair_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_step_count", step_count, 0);
        chk("rst_fail_index", fail_index, 32'hFFFF_FFFF);
        chk("rst_step0", bus.pair_step0, 0);
        chk("rst_step1", bus.pair_step1, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", bus.in_ready, 1);

        // Three-step trace, first pair stalled for 5 cycles, both pairs ok.
        send_step(0, 1'b0);
        chk("no_pair_after_first_step", bus.pair_valid, 0);
        send_step(1, 1'b0);
        chk("pair_latency", bus.pair_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_pair_valid", bus.pair_valid, 1);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_step0", bus.pair_step0, exp_step(0));
            chk("stall_step1", bus.pair_step1, exp_step(1));
            chk("stall_count", step_count, 0);
        end
        handshake(1'b1);
        chk("count_after_release", step_count, 1);
        chk("pv_low_after_hs", bus.pair_valid, 0);
        chk("step0_shifted", bus.pair_step0, exp_step(1));
        send_step(2, 1'b1);
        chk("pair2_step0", bus.pair_step0, exp_step(1));
        chk("pair2_step1", bus.pair_step1, exp_step(2));
        handshake(1'b1);
        chk("ok_done", done, 1);
        chk("ok_pass", pass, 1);
        chk("ok_count", step_count, 2);
        chk("ok_fail_index", fail_index, 32'hFFFF_FFFF);
        chk("done_in_ready", bus.in_ready, 0);

        // Second pair fails.
        do_reset();
        run_pair_trace(1'b1, 1'b0);
        chk("f2_done", done, 1);
        chk("f2_fail_index", fail_index, 1);
        chk("f2_count", step_count, 2);
        chk("f2_pass", pass, 0);

        // Both pairs fail; the first failure is kept.
        do_reset();
        run_pair_trace(1'b0, 1'b0);
        chk("f01_fail_index", fail_index, 0);
        chk("f01_count", step_count, 2);
        chk("f01_pass", pass, 0);

        // in_last on word 7 of step 1.
        do_reset();
        send_step(0, 1'b0);
        for (int w = 0; w < 7; w++) send_word(word_of(1, w), 1'b0);
        send_word(word_of(1, 7), 1'b1);
        chk("fe_frame_err", frame_err, 1);
        chk("fe_done", done, 1);
        chk("fe_pass", pass, 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("fe_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        chk("fe_count", step_count, 0);

        // Single-step trace.
        do_reset();
        saw_pv = 1'b0;
        send_step(4, 1'b1);
        repeat (3) @(negedge clk);
        chk("single_no_pair", saw_pv, 0);
        chk("single_done", done, 1);
        chk("single_pass", pass, 1);
        chk("single_count", step_count, 0);

        // Reset during word 10 of step 2, then a fresh two-step trace.
        do_reset();
        send_step(5, 1'b0);
        for (int w = 0; w < 10; w++) send_word(word_of(6, w), 1'b0);
        @(negedge clk);
        bus.in_data  = word_of(6, 10);
        bus.in_valid = 1'b1;
        rst          = 1'b1;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_step0", bus.pair_step0, 0);
        chk("mid_rst_count", step_count, 0);
        chk("mid_rst_fail_index", fail_index, 32'hFFFF_FFFF);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        @(posedge clk);
        #1;
        send_step(7, 1'b0);
        chk("fresh_no_pair", bus.pair_valid, 0);
        send_step(8, 1'b1);
        chk("fresh_pair_valid", bus.pair_valid, 1);
        chk("fresh_step0", bus.pair_step0, exp_step(7));
        chk("fresh_step1", bus.pair_step1, exp_step(8));
        chk("fresh_word20_bits", bus.pair_step1[655:640], 16'h0814);
        handshake(1'b1);
        chk("fresh_count", step_count, 1);
        chk("fresh_done", done, 1);
        chk("fresh_pass", pass, 1);
        chk("fresh_fail_index", fail_index, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
